// File: rtl/shift_frame_controller.sv
// ---------------------------------------------------------------------------
// shift_frame_controller
//
// Purpose: assembles a serial bit stream (MSB first) into bytes and presents
// them on a valid/ready output handshake. A start command opens a frame of
// FRAME_BYTES bytes. A completed byte that cannot be posted because the
// output slot is still occupied is parked in WAIT until the consumer drains
// the slot.
//
// Ports:
//   clk         in   clock, all state changes on rising edge
//   reset       in   synchronous active-high reset
//   start       in   begin a frame (honoured only in IDLE)
//   abort       in   drop the frame in progress, return to IDLE
//   d_in        in   serial data bit
//   d_valid     in   d_in qualifier
//   byte_ready  in   consumer accepts byte_out this cycle
//   byte_out    out  [7:0] assembled byte, first bit received in bit 7
//   byte_valid  out  byte_out holds a byte not yet accepted
//   busy        out  high whenever the FSM is not in IDLE
//   bit_cnt     out  [2:0] bits accepted into the current byte
//   overrun     out  sticky: a bit arrived while parked in WAIT
// ---------------------------------------------------------------------------
module shift_frame_controller #(
  parameter int FRAME_BYTES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       d_in,
  input  logic       d_valid,
  input  logic       byte_ready,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       busy,
  output logic [2:0] bit_cnt,
  output logic       overrun
);

  localparam logic [7:0] FRAME_LEN = 8'(FRAME_BYTES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t     state_q;
  logic [6:0] sr_q;        // bits of the byte under assembly (oldest in bit 6)
  logic [7:0] hold_q;      // completed byte parked while the slot is occupied
  logic [7:0] byte_out_q;
  logic       byte_valid_q;
  logic [7:0] byte_cnt_q;  // bytes completed in the current frame
  logic [2:0] bit_cnt_q;
  logic       overrun_q;

  logic [7:0] byte_d;      // byte formed if the current bit is the 8th
  logic [7:0] byte_cnt_d;
  logic       slot_free;
  logic       frame_done;

  always_comb begin
    byte_d     = {sr_q, d_in};
    byte_cnt_d = byte_cnt_q + 8'd1;
    // The slot counts as free if it is empty or is being drained this edge.
    slot_free  = !byte_valid_q || byte_ready;
    frame_done = (byte_cnt_d == FRAME_LEN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      sr_q         <= '0;
      hold_q       <= '0;
      byte_out_q   <= '0;
      byte_valid_q <= 1'b0;
      byte_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      overrun_q    <= 1'b0;
    end else begin
      // Output handshake runs independently of the FSM; a byte loaded below
      // on the same edge overrides this clear.
      if (byte_valid_q && byte_ready) begin
        byte_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            state_q    <= SHIFT;
            sr_q       <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            overrun_q  <= 1'b0;
          end
        end

        SHIFT: begin
          if (abort) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            bit_cnt_q <= '0;
          end else if (d_valid) begin
            sr_q      <= byte_d[6:0];
            bit_cnt_q <= bit_cnt_q + 3'd1;  // wraps 7 -> 0 on the 8th bit
            if (bit_cnt_q == 3'd7) begin
              if (slot_free) begin
                byte_out_q   <= byte_d;
                byte_valid_q <= 1'b1;
                byte_cnt_q   <= byte_cnt_d;
                state_q      <= frame_done ? IDLE : SHIFT;
              end else begin
                hold_q  <= byte_d;
                state_q <= WAIT;
              end
            end
          end
        end

        WAIT: begin
          if (abort) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            hold_q    <= '0;
            bit_cnt_q <= '0;
          end else begin
            // No room to store further bits: drop them and flag it.
            if (d_valid) begin
              overrun_q <= 1'b1;
            end
            // byte_valid is necessarily set here, so ready frees the slot.
            if (byte_ready) begin
              byte_out_q   <= hold_q;
              byte_valid_q <= 1'b1;
              byte_cnt_q   <= byte_cnt_d;
              state_q      <= frame_done ? IDLE : SHIFT;
            end
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign byte_out   = byte_out_q;
  assign byte_valid = byte_valid_q;
  assign busy       = (state_q != IDLE);
  assign bit_cnt    = bit_cnt_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_shift_frame_controller.sv
// ---------------------------------------------------------------------------
// tb_shift_frame_controller
//
// Directed bench. Two instances share all inputs: u1 with FRAME_BYTES=1 and
// u2 with FRAME_BYTES=2. Inputs are driven 1 time unit after a rising edge
// and outputs are sampled 1 time unit after the following rising edge.
// ---------------------------------------------------------------------------
module tb_shift_frame_controller;

  logic clk = 1'b0;
  logic reset, start, abort, d_in, d_valid, byte_ready;

  logic [7:0] u1_byte_out, u2_byte_out;
  logic       u1_byte_valid, u2_byte_valid;
  logic       u1_busy, u2_busy;
  logic [2:0] u1_bit_cnt, u2_bit_cnt;
  logic       u1_overrun, u2_overrun;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  shift_frame_controller #(.FRAME_BYTES(1)) u1 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .d_in(d_in),
    .d_valid(d_valid), .byte_ready(byte_ready), .byte_out(u1_byte_out),
    .byte_valid(u1_byte_valid), .busy(u1_busy), .bit_cnt(u1_bit_cnt),
    .overrun(u1_overrun)
  );

  shift_frame_controller #(.FRAME_BYTES(2)) u2 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .d_in(d_in),
    .d_valid(d_valid), .byte_ready(byte_ready), .byte_out(u2_byte_out),
    .byte_valid(u2_byte_valid), .busy(u2_busy), .bit_cnt(u2_bit_cnt),
    .overrun(u2_overrun)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    d_in    = b;
    d_valid = 1'b1;
    tick();
    d_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    d_in = 1'b0; d_valid = 1'b0; byte_ready = 1'b0;
    #1;
    tick();
    tick();

    // Reset state
    chk("rst_byte_out", u2_byte_out, 8'h00);
    chk("rst_byte_valid", 8'(u2_byte_valid), 8'd0);
    chk("rst_busy", 8'(u2_busy), 8'd0);
    chk("rst_bit_cnt", 8'(u2_bit_cnt), 8'd0);
    chk("rst_overrun", 8'(u2_overrun), 8'd0);
    chk("rst_u1_busy", 8'(u1_busy), 8'd0);
    reset = 1'b0;

    // Single-byte frame with consumer always ready: 1,0,1,1,0,0,1,0 -> B2
    byte_ready = 1'b1;
    pulse_start();
    chk("b2_busy_after_start", 8'(u1_busy), 8'd1);
    chk("b2_bitcnt_after_start", 8'(u1_bit_cnt), 8'd0);
    send_byte(8'hB2);
    chk("b2_byte_out", u1_byte_out, 8'hB2);
    chk("b2_byte_valid", 8'(u1_byte_valid), 8'd1);
    chk("b2_idle_busy", 8'(u1_busy), 8'd0);
    chk("b2_u2_still_busy", 8'(u2_busy), 8'd1);
    tick();
    chk("b2_valid_cleared", 8'(u1_byte_valid), 8'd0);

    // Two-byte frame with consumer stalled: A5 posted, 3C parked in WAIT
    reset = 1'b1;
    tick();
    reset = 1'b0;
    byte_ready = 1'b0;
    pulse_start();
    send_byte(8'hA5);
    chk("a5_byte_out", u2_byte_out, 8'hA5);
    chk("a5_byte_valid", 8'(u2_byte_valid), 8'd1);
    chk("a5_bit_cnt_wrap", 8'(u2_bit_cnt), 8'd0);
    chk("a5_busy", 8'(u2_busy), 8'd1);
    send_byte(8'h3C);
    chk("wait_byte_out_stable", u2_byte_out, 8'hA5);
    chk("wait_byte_valid", 8'(u2_byte_valid), 8'd1);
    chk("wait_busy", 8'(u2_busy), 8'd1);
    chk("wait_no_overrun_yet", 8'(u2_overrun), 8'd0);
    send_bit(1'b1);
    chk("wait_overrun_set", 8'(u2_overrun), 8'd1);
    chk("wait_overrun_out_stable", u2_byte_out, 8'hA5);
    byte_ready = 1'b1;
    tick();
    byte_ready = 1'b0;
    chk("3c_byte_out", u2_byte_out, 8'h3C);
    chk("3c_byte_valid", 8'(u2_byte_valid), 8'd1);
    chk("3c_idle_busy", 8'(u2_busy), 8'd0);
    tick();
    chk("idle_overrun_sticky", 8'(u2_overrun), 8'd1);
    chk("idle_pending_valid", 8'(u2_byte_valid), 8'd1);
    chk("idle_pending_out", u2_byte_out, 8'h3C);
    pulse_start();
    chk("start_with_pending_busy", 8'(u2_busy), 8'd1);
    chk("start_clears_overrun", 8'(u2_overrun), 8'd0);
    chk("start_keeps_valid", 8'(u2_byte_valid), 8'd1);

    // Abort after 5 bits, then a fresh frame of FF
    byte_ready = 1'b1;
    tick();
    chk("drain_valid", 8'(u2_byte_valid), 8'd0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    chk("five_bits_cnt", 8'(u2_bit_cnt), 8'd5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 8'(u2_busy), 8'd0);
    chk("abort_bit_cnt", 8'(u2_bit_cnt), 8'd0);
    chk("abort_no_valid", 8'(u2_byte_valid), 8'd0);
    pulse_start();
    send_byte(8'hFF);
    chk("ff_byte_out", u2_byte_out, 8'hFF);
    chk("ff_byte_valid", 8'(u2_byte_valid), 8'd1);

    // start+abort in IDLE, gaps in d_valid, abort on the 8th bit
    abort = 1'b1;
    tick();
    chk("abort_keeps_byte_out", u2_byte_out, 8'hFF);
    chk("abort_drained_valid", 8'(u2_byte_valid), 8'd0);
    start = 1'b1;
    tick();
    chk("start_abort_idle", 8'(u2_busy), 8'd0);
    abort = 1'b0;
    tick();
    start = 1'b0;
    chk("start_after_abort", 8'(u2_busy), 8'd1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    tick();
    tick();
    chk("gap_bit_cnt_held", 8'(u2_bit_cnt), 8'd4);
    chk("gap_byte_out_held", u2_byte_out, 8'hFF);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    chk("gap_byte_96", u2_byte_out, 8'h96);
    chk("gap_valid_96", 8'(u2_byte_valid), 8'd1);
    for (int i = 0; i < 7; i++) send_bit(1'b0);
    chk("seven_bits_cnt", 8'(u2_bit_cnt), 8'd7);
    abort = 1'b1;
    send_bit(1'b1);
    abort = 1'b0;
    chk("abort8_busy", 8'(u2_busy), 8'd0);
    chk("abort8_bit_cnt", 8'(u2_bit_cnt), 8'd0);
    chk("abort8_no_byte", 8'(u2_byte_valid), 8'd0);
    chk("abort8_byte_out", u2_byte_out, 8'h96);

    // Reset mid-frame with a pending byte; start ignored while shifting
    byte_ready = 1'b0;
    pulse_start();
    send_byte(8'h5A);
    chk("5a_byte_out", u2_byte_out, 8'h5A);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    chk("three_bits_cnt", 8'(u2_bit_cnt), 8'd3);
    pulse_start();
    chk("start_ignored_cnt", 8'(u2_bit_cnt), 8'd3);
    chk("start_ignored_busy", 8'(u2_busy), 8'd1);
    chk("pre_reset_valid", 8'(u2_byte_valid), 8'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_byte_out", u2_byte_out, 8'h00);
    chk("mid_rst_valid", 8'(u2_byte_valid), 8'd0);
    chk("mid_rst_busy", 8'(u2_busy), 8'd0);
    chk("mid_rst_bit_cnt", 8'(u2_bit_cnt), 8'd0);
    chk("mid_rst_overrun", 8'(u2_overrun), 8'd0);
    tick();
    chk("post_rst_idle", 8'(u2_busy), 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
